lfsr_sequence_checker: RTL and testbench

LFSR_SEQUENCE_CHECKER -- requirements
Module: lfsr_sequence_checker

---
 rtl/lfsr_sequence_checker.sv | 114 +++++++++++
 tb/tb_lfsr_sequence_checker.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_sequence_checker.sv
// lfsr_sequence_checker: locks onto an x^4+x^3+1 LFSR word stream and flags mismatching words once locked
// Ports: clk, reset (async, active-high), in_valid/data_in (received word), err_clr (sync clear of err_count),
//        locked, mismatch (one-cycle pulse), err_count (saturating), expected (predicted next word).
// Macro LFSR_CHK_ERRCNT_EN builds the error counter; when undefined err_count reads 0 and err_clr is ignored.
module lfsr_sequence_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] data_in,
  input  logic       err_clr,
  output logic       locked,
  output logic       mismatch,
  output logic [7:0] err_count,
  output logic [3:0] expected
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t     r_state, w_state;
  logic [3:0] r_expected, w_expected;
  logic [2:0] r_match, w_match, r_miss, w_miss;
  logic       r_mismatch, w_mismatch, r_locked;
  function automatic logic [3:0] nxt(input logic [3:0] w);
    return {w[2:0], w[3] ^ w[2]};
  endfunction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= HUNT;
      r_expected <= 4'd0;
      r_match    <= 3'd0;
      r_miss     <= 3'd0;
      r_mismatch <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_expected <= w_expected;
      r_match    <= w_match;
      r_miss     <= w_miss;
      r_mismatch <= w_mismatch;
      r_locked   <= w_state == LOCKED;
    end
  end
  always_comb begin
    w_state    = r_state;
    w_expected = r_expected;
    w_match    = r_match;
    w_miss     = r_miss;
    w_mismatch = 1'b0;
    if (in_valid) begin
      case (r_state)
        HUNT: begin
          if (data_in != 4'd0) begin
            w_expected = nxt(data_in);
            w_match    = 3'd0;
            w_state    = VERIFY;
          end
        end
        VERIFY: begin
          if (data_in == r_expected) begin
            w_expected = nxt(r_expected);
            w_match    = r_match + 3'd1;
            if (w_match == 3'(LOCK_COUNT)) begin
              w_state = LOCKED;
              w_miss  = 3'd0;
            end
          end else if (data_in != 4'd0) begin
            w_expected = nxt(data_in);
            w_match    = 3'd0;
          end else begin
            w_match = 3'd0;
            w_state = HUNT;
          end
        end
        LOCKED: begin
          // flywheel: the prediction advances whether or not the word matched
          w_expected = nxt(r_expected);
          if (data_in == r_expected) begin
            w_miss = 3'd0;
          end else begin
            w_mismatch = 1'b1;
            w_miss     = r_miss + 3'd1;
            if (w_miss == 3'(LOSS_COUNT)) begin
              w_state = HUNT;
              w_miss  = 3'd0;
              w_match = 3'd0;
            end
          end
        end
        default: w_state = HUNT;
      endcase
    end
  end
  assign locked   = r_locked;
  assign mismatch = r_mismatch;
  assign expected = r_expected;
`ifdef LFSR_CHK_ERRCNT_EN
  logic [7:0] r_err;
  // a clear coinciding with a mismatch keeps that mismatch counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_err <= 8'd0;
    else if (err_clr)
      r_err <= {7'd0, w_mismatch};
    else if (w_mismatch && r_err != 8'hFF)
      r_err <= r_err + 8'd1;
  end
  assign err_count = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err_count        = 8'd0;
`endif
endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// tb_lfsr_sequence_checker: directed self-checking bench for lfsr_sequence_checker
module tb_lfsr_sequence_checker;
  logic       clk = 1'b0;
  logic       reset, in_valid, err_clr;
  logic [3:0] data_in;
  logic       locked, mismatch;
  logic [7:0] err_count;
  logic [3:0] expected;
  int pass_cnt = 0;
  int total = 0;
  int idx;
  logic [3:0] seq [15] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001,
                           4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111};
`ifdef LFSR_CHK_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  lfsr_sequence_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .err_clr(err_clr),
    .locked(locked), .mismatch(mismatch), .err_count(err_count), .expected(expected)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] eerr(input int n);
    return ERR_EN ? 8'(n) : 8'd0;
  endfunction
  task automatic send(input logic v, input logic [3:0] d, input logic c);
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    err_clr  = c;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; data_in = 4'd0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({locked, mismatch, err_count, expected} !== 14'd0)
      $display("FAIL reset: got l=%b m=%b err=%0d exp=%b, want all 0", locked, mismatch, err_count, expected);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_acquire;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, seq[i], 1'b0);
      total++;
      if (locked !== (i == 3) || mismatch !== 1'b0 || expected !== seq[i+1] || err_count !== 8'd0)
        $display("FAIL acquire[%0d]: got l=%b m=%b exp=%b err=%0d, want l=%b m=0 exp=%b err=0",
                 i, locked, mismatch, expected, err_count, i == 3, seq[i+1]);
      else pass_cnt++;
    end
    idx = 4;
  endtask
  task automatic test_single_error;
    send(1'b1, 4'b0000, 1'b0);
    total++;
    if (mismatch !== 1'b1 || locked !== 1'b1 || expected !== 4'b0010 || err_count !== eerr(1))
      $display("FAIL single_err: got m=%b l=%b exp=%b err=%0d, want m=1 l=1 exp=0010 err=%0d",
               mismatch, locked, expected, err_count, eerr(1));
    else pass_cnt++;
    send(1'b1, 4'b0010, 1'b0);
    total++;
    if (mismatch !== 1'b0 || locked !== 1'b1 || expected !== 4'b0100 || err_count !== eerr(1))
      $display("FAIL single_err_recover: got m=%b l=%b exp=%b err=%0d, want m=0 l=1 exp=0100 err=%0d",
               mismatch, locked, expected, err_count, eerr(1));
    else pass_cnt++;
  endtask
  task automatic test_gap;
    send(1'b0, 4'h5, 1'b0);
    total++;
    if (mismatch !== 1'b0 || locked !== 1'b1 || expected !== 4'b0100 || err_count !== eerr(1))
      $display("FAIL gap: got m=%b l=%b exp=%b err=%0d, want m=0 l=1 exp=0100 err=%0d",
               mismatch, locked, expected, err_count, eerr(1));
    else pass_cnt++;
  endtask
  task automatic test_loss;
    send(1'b1, 4'b0000, 1'b0);
    total++;
    if (mismatch !== 1'b1 || locked !== 1'b1 || expected !== 4'b1001 || err_count !== eerr(2))
      $display("FAIL loss_1: got m=%b l=%b exp=%b err=%0d, want m=1 l=1 exp=1001 err=%0d",
               mismatch, locked, expected, err_count, eerr(2));
    else pass_cnt++;
    send(1'b1, 4'b0000, 1'b0);
    total++;
    if (mismatch !== 1'b1 || locked !== 1'b0 || expected !== 4'b0011 || err_count !== eerr(3))
      $display("FAIL loss_2: got m=%b l=%b exp=%b err=%0d, want m=1 l=0 exp=0011 err=%0d",
               mismatch, locked, expected, err_count, eerr(3));
    else pass_cnt++;
  endtask
  task automatic test_zero_reseed;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 4'b0000, 1'b0);
      total++;
      if (mismatch !== 1'b0 || locked !== 1'b0 || expected !== 4'b0011 || err_count !== eerr(3))
        $display("FAIL hunt_zero[%0d]: got m=%b l=%b exp=%b err=%0d, want m=0 l=0 exp=0011 err=%0d",
                 i, mismatch, locked, expected, err_count, eerr(3));
      else pass_cnt++;
    end
    send(1'b1, 4'b1111, 1'b0);
    total++;
    if (mismatch !== 1'b0 || locked !== 1'b0 || expected !== 4'b1110)
      $display("FAIL hunt_seed: got m=%b l=%b exp=%b, want m=0 l=0 exp=1110", mismatch, locked, expected);
    else pass_cnt++;
    send(1'b1, 4'b0101, 1'b0);
    total++;
    if (mismatch !== 1'b0 || locked !== 1'b0 || expected !== 4'b1011 || err_count !== eerr(3))
      $display("FAIL reseed: got m=%b l=%b exp=%b err=%0d, want m=0 l=0 exp=1011 err=%0d",
               mismatch, locked, expected, err_count, eerr(3));
    else pass_cnt++;
  endtask
  task automatic test_wrap;
    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 1) send(1'b0, 4'h0, 1'b0);
      else begin
        send(1'b1, seq[idx % 15], 1'b0);
        idx++;
      end
      total++;
      if (mismatch !== 1'b0 || locked !== 1'b1 || expected !== seq[idx % 15])
        $display("FAIL wrap[%0d]: got m=%b l=%b exp=%b, want m=0 l=1 exp=%b",
                 k, mismatch, locked, expected, seq[idx % 15]);
      else pass_cnt++;
    end
  endtask
  task automatic test_err_async_reset;
    for (int j = 0; j < 5; j++) begin
      send(1'b1, seq[idx % 15] ^ 4'h3, 1'b0);
      idx++;
      total++;
      if (mismatch !== 1'b1 || locked !== 1'b1 || expected !== seq[idx % 15] || err_count !== eerr(j + 1))
        $display("FAIL err_accum[%0d]: got m=%b l=%b exp=%b err=%0d, want m=1 l=1 exp=%b err=%0d",
                 j, mismatch, locked, expected, err_count, seq[idx % 15], eerr(j + 1));
      else pass_cnt++;
      send(1'b1, seq[idx % 15], 1'b0);
      idx++;
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({locked, mismatch, err_count, expected} !== 14'd0)
      $display("FAIL async_reset: got l=%b m=%b err=%0d exp=%b, want all 0", locked, mismatch, err_count, expected);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; err_clr = 1'b0;
  endtask
  task automatic test_err_clr;
    test_acquire();
    send(1'b1, 4'b1111, 1'b0);
    send(1'b1, 4'b0010, 1'b0);
    total++;
    if (err_count !== eerr(1) || locked !== 1'b1)
      $display("FAIL clr_pre: got err=%0d l=%b, want err=%0d l=1", err_count, locked, eerr(1));
    else pass_cnt++;
    send(1'b1, 4'b1111, 1'b1);
    total++;
    if (mismatch !== 1'b1 || err_count !== eerr(1) || expected !== 4'b1001)
      $display("FAIL clr_with_mismatch: got m=%b err=%0d exp=%b, want m=1 err=%0d exp=1001",
               mismatch, err_count, expected, eerr(1));
    else pass_cnt++;
    send(1'b1, 4'b1001, 1'b1);
    total++;
    if (mismatch !== 1'b0 || err_count !== 8'd0 || locked !== 1'b1)
      $display("FAIL clr_alone: got m=%b err=%0d l=%b, want m=0 err=0 l=1", mismatch, err_count, locked);
    else pass_cnt++;
  endtask
  initial begin
    reset = 1'b0; in_valid = 1'b0; data_in = 4'd0; err_clr = 1'b0;
    test_reset();
    test_acquire();
    test_single_error();
    test_gap();
    test_loss();
    test_zero_reseed();
    test_reset();
    test_acquire();
    test_wrap();
    test_err_async_reset();
    test_err_clr();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
